// File: rtl/stack_queue.sv
// Parametrised LIFO/FIFO buffer with registered pop data, one-cycle Valid pulse,
// occupancy count and sticky overflow/underflow flags.
module stack_queue #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Clear,
   input  logic             Mode,
   input  logic             Push,
   input  logic             Pop,
   input  logic [WIDTH-1:0] Data_In,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Valid,
   output logic             Full,
   output logic             Empty,
   output logic [CW-1:0]    Count,
   output logic             Overflow,
   output logic             Underflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic             fifo_q, fifo_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             pop_ok;
   logic             push_ok;
   logic             mem_we;
   logic [PW-1:0]    top_idx;
   logic [PW-1:0]    rd_idx;
   logic [PW-1:0]    wr_idx;

   // Increment with wrap at DEPTH-1, so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Effective-operation decode and slot selection.
   always_comb begin
      pop_ok  = Pop && !empty_q;
      push_ok = Push && (!full_q || pop_ok);
      mem_we  = !Clear && push_ok;
      top_idx = PW'(count_q - CW'(1));
      rd_idx  = fifo_q ? rd_ptr_q : top_idx;
      // A LIFO push+pop overwrites the slot being popped.
      if (fifo_q) begin
         wr_idx = wr_ptr_q;
      end else if (pop_ok) begin
         wr_idx = top_idx;
      end else begin
         wr_idx = PW'(count_q);
      end
   end

   // Next-state computation; Clear overrides Push/Pop.
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = 1'b0;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (Clear) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
         if (pop_ok) begin
            dout_d  = mem[rd_idx];
            valid_d = 1'b1;
            if (fifo_q) begin
               rd_ptr_d = ptr_inc(rd_ptr_q);
            end
         end
         if (push_ok && fifo_q) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (Push && !push_ok) begin
            ovf_d = 1'b1;
         end
         if (Pop && !pop_ok) begin
            unf_d = 1'b1;
         end
      end

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
      // Access order may only change while nothing is resident.
      fifo_d  = empty_d ? Mode : fifo_q;
   end

   // Control and output registers.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fifo_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         valid_q  <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fifo_q   <= fifo_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem[wr_idx] <= Data_In;
      end
   end

   assign Data_Out  = dout_q;
   assign Valid     = valid_q;
   assign Full      = full_q;
   assign Empty     = empty_q;
   assign Count     = count_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;

endmodule

// File: tb/tb_stack_queue.sv
// Bench for stack_queue (WIDTH=8, DEPTH=4): directed vector table, randomized
// run against a queue-based reference model, and an asynchronous reset sequence.
module tb_stack_queue;

   localparam int unsigned W   = 8;
   localparam int unsigned D   = 4;
   localparam int unsigned CWT = $clog2(D + 1);

   logic           Clk = 1'b0;
   logic           RstN = 1'b0;
   logic           Clear = 1'b0;
   logic           Mode = 1'b0;
   logic           Push = 1'b0;
   logic           Pop = 1'b0;
   logic [W-1:0]   Data_In = '0;
   logic [W-1:0]   Data_Out;
   logic           Valid;
   logic           Full;
   logic           Empty;
   logic [CWT-1:0] Count;
   logic           Overflow;
   logic           Underflow;

   stack_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .Clk(Clk), .RstN(RstN), .Clear(Clear), .Mode(Mode), .Push(Push), .Pop(Pop),
      .Data_In(Data_In), .Data_Out(Data_Out), .Valid(Valid), .Full(Full),
      .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         clr, mode, push, pop;
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         v;
      int           cnt;
      logic         o, u;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic clr, input logic mode, input logic push, input logic pop,
                      input logic [W-1:0] din, input logic [W-1:0] dout, input logic v,
                      input int cnt, input logic o, input logic u);
      vec_t e;
      e.clr = clr; e.mode = mode; e.push = push; e.pop = pop; e.din = din;
      e.dout = dout; e.v = v; e.cnt = cnt; e.o = o; e.u = u;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [W-1:0] e_dout, input logic e_v,
                        input int e_cnt, input logic e_o, input logic e_u);
      logic ok;
      n_checks++;
      ok = (Data_Out === e_dout) && (Valid === e_v) && (Count === CWT'(e_cnt)) &&
           (Full === (e_cnt == D)) && (Empty === (e_cnt == 0)) &&
           (Overflow === e_o) && (Underflow === e_u);
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got dout=%h v=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b; want dout=%h v=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, Data_Out, Valid, Count, Full, Empty, Overflow, Underflow,
                  e_dout, e_v, e_cnt, (e_cnt == D), (e_cnt == 0), e_o, e_u);
      end
   endtask

   task automatic drive(input logic clr, input logic mode, input logic push, input logic pop,
                        input logic [W-1:0] din);
      Clear = clr; Mode = mode; Push = push; Pop = pop; Data_In = din;
      @(posedge Clk);
      #1;
   endtask

   // Reference model: a plain queue; LIFO pops the back, FIFO pops the front.
   logic [W-1:0] mq[$];
   logic         m_fifo = 1'b0;
   logic [W-1:0] m_dout = '0;
   logic         m_v = 1'b0;
   logic         m_o = 1'b0;
   logic         m_u = 1'b0;

   task automatic model_step(input logic clr, input logic mode, input logic push,
                             input logic pop, input logic [W-1:0] din);
      m_v = 1'b0;
      if (clr) begin
         mq.delete();
         m_o = 1'b0;
         m_u = 1'b0;
      end else if (pop && mq.size() > 0) begin
         m_dout = m_fifo ? mq.pop_front() : mq.pop_back();
         m_v    = 1'b1;
         if (push) mq.push_back(din);
      end else begin
         if (pop) m_u = 1'b1;
         if (push) begin
            if (mq.size() == D) m_o = 1'b1;
            else mq.push_back(din);
         end
      end
      if (mq.size() == 0) m_fifo = mode;
   endtask

   initial begin
      logic         r_clr, r_mode, r_push, r_pop;
      logic [W-1:0] r_din;

      // LIFO fill, overflow, drain, underflow, clear
      add(0,0,0,0,8'h00, 8'h00,0,0,0,0);
      add(0,0,1,0,8'h11, 8'h00,0,1,0,0);
      add(0,0,1,0,8'h22, 8'h00,0,2,0,0);
      add(0,0,1,0,8'h33, 8'h00,0,3,0,0);
      add(0,0,1,0,8'h44, 8'h00,0,4,0,0);
      add(0,0,1,0,8'h55, 8'h00,0,4,1,0);
      add(0,0,0,1,8'h00, 8'h44,1,3,1,0);
      add(0,0,0,1,8'h00, 8'h33,1,2,1,0);
      add(0,0,0,1,8'h00, 8'h22,1,1,1,0);
      add(0,0,0,1,8'h00, 8'h11,1,0,1,0);
      add(0,0,0,1,8'h00, 8'h11,0,0,1,1);
      add(1,1,1,1,8'hEE, 8'h11,0,0,0,0);
      add(0,1,0,0,8'h00, 8'h11,0,0,0,0);
      // FIFO with pointer wrap
      add(0,1,1,0,8'hA0, 8'h11,0,1,0,0);
      add(0,1,1,0,8'hA1, 8'h11,0,2,0,0);
      add(0,1,1,0,8'hA2, 8'h11,0,3,0,0);
      add(0,1,1,0,8'hA3, 8'h11,0,4,0,0);
      add(0,1,0,1,8'h00, 8'hA0,1,3,0,0);
      add(0,1,0,1,8'h00, 8'hA1,1,2,0,0);
      add(0,1,1,0,8'hA4, 8'hA1,0,3,0,0);
      add(0,1,1,0,8'hA5, 8'hA1,0,4,0,0);
      add(0,1,0,1,8'h00, 8'hA2,1,3,0,0);
      add(0,1,0,1,8'h00, 8'hA3,1,2,0,0);
      add(0,1,0,1,8'h00, 8'hA4,1,1,0,0);
      add(0,1,0,1,8'h00, 8'hA5,1,0,0,0);
      // FIFO push+pop with {5,6}, then push+pop on empty
      add(0,1,1,0,8'h05, 8'hA5,0,1,0,0);
      add(0,1,1,0,8'h06, 8'hA5,0,2,0,0);
      add(0,1,1,1,8'h07, 8'h05,1,2,0,0);
      add(0,1,0,1,8'h00, 8'h06,1,1,0,0);
      add(0,1,0,1,8'h00, 8'h07,1,0,0,0);
      add(0,1,1,1,8'h99, 8'h07,0,1,0,1);
      add(0,1,0,1,8'h00, 8'h99,1,0,0,1);
      add(1,0,0,0,8'h00, 8'h99,0,0,0,0);
      // LIFO full push+pop
      add(0,0,1,0,8'h01, 8'h99,0,1,0,0);
      add(0,0,1,0,8'h02, 8'h99,0,2,0,0);
      add(0,0,1,0,8'h03, 8'h99,0,3,0,0);
      add(0,0,1,0,8'h04, 8'h99,0,4,0,0);
      add(0,0,1,1,8'h09, 8'h04,1,4,0,0);
      add(0,0,0,1,8'h00, 8'h09,1,3,0,0);
      add(0,0,0,1,8'h00, 8'h03,1,2,0,0);
      add(0,0,0,1,8'h00, 8'h02,1,1,0,0);
      add(0,0,0,1,8'h00, 8'h01,1,0,0,0);
      // Mode toggled with data resident is ignored until drained
      add(0,0,1,0,8'h61, 8'h01,0,1,0,0);
      add(0,1,1,0,8'h62, 8'h01,0,2,0,0);
      add(0,1,0,1,8'h00, 8'h62,1,1,0,0);
      add(0,1,0,1,8'h00, 8'h61,1,0,0,0);
      add(0,1,1,0,8'h71, 8'h61,0,1,0,0);
      add(0,1,1,0,8'h72, 8'h61,0,2,0,0);
      add(0,1,0,1,8'h00, 8'h71,1,1,0,0);
      add(0,1,0,1,8'h00, 8'h72,1,0,0,0);

      #12;
      check("reset_state", 8'h00, 1'b0, 0, 1'b0, 1'b0);
      RstN = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].clr, tbl[i].mode, tbl[i].push, tbl[i].pop, tbl[i].din);
         check($sformatf("vec%0d", i), tbl[i].dout, tbl[i].v, tbl[i].cnt, tbl[i].o, tbl[i].u);
      end

      // Randomized run; first cycle is a clear so the model starts in sync.
      m_dout = 8'h72;
      r_mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         r_clr  = (i == 0) || ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 7) == 0) r_mode = ~r_mode;
         r_push = ($urandom_range(0, 99) < 55);
         r_pop  = ($urandom_range(0, 99) < 50);
         r_din  = W'($urandom);
         model_step(r_clr, r_mode, r_push, r_pop, r_din);
         drive(r_clr, r_mode, r_push, r_pop, r_din);
         check($sformatf("rand%0d", i), m_dout, m_v, mq.size(), m_o, m_u);
      end

      // Asynchronous reset in the middle of a pop burst
      drive(1, 0, 0, 0, 8'h00);
      check("arst_clear", m_dout, 1'b0, 0, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 8'h00);
      drive(0, 0, 1, 0, 8'hC1);
      drive(0, 0, 1, 0, 8'hC2);
      drive(0, 0, 1, 0, 8'hC3);
      drive(0, 0, 1, 0, 8'hC4);
      drive(0, 0, 0, 1, 8'h00);
      check("arst_pop1", 8'hC4, 1'b1, 3, 1'b0, 1'b0);
      Pop = 1'b1;
      #3;
      RstN = 1'b0;
      #1;
      check("arst_immediate", 8'h00, 1'b0, 0, 1'b0, 1'b0);
      Pop = 1'b0;
      @(posedge Clk);
      #1;
      check("arst_held", 8'h00, 1'b0, 0, 1'b0, 1'b0);
      #2;
      RstN = 1'b1;
      drive(0, 0, 0, 1, 8'h00);
      check("arst_first_pop", 8'h00, 1'b0, 0, 1'b0, 1'b1);
      drive(0, 0, 0, 0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_queue.md
# stack_queue

Parametrised LIFO/FIFO buffer with registered pop data, a one-cycle read-valid pulse, an occupancy count and sticky error flags. It succeeds the fixed 8x4 stack in the lab datapath. Depth and width are generic, and the access order is selectable per session. Simultaneous push/pop is supported, and a synchronous flush is provided. Producers and consumers drive single-cycle Push/Pop strobes directly.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 16: number of entries (≥2; need not be a power of two).
- CW, $clog2(DEPTH+1): width of Count (derived; not overridden).
- Clk  input  1  clock; all state changes on rising edge.
- RstN  input  1  reset, asynchronous, active-low.
- Clear  input  1  synchronous flush; priority over Push/Pop.
- Mode  input  1  0 = LIFO, 1 = FIFO; latched only while empty.
- Push  input  1  write strobe, one word per cycle.
- Pop  input  1  read strobe, one word per cycle.
- Data_In  input  WIDTH  word written on Push.
- Data_Out  output  WIDTH  last popped word, registered, held until next pop.
- Valid  output  1  high for exactly one cycle after an effective pop.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Count  output  CW  current occupancy, 0..DEPTH.
- Overflow  output  1  sticky: push rejected while full.
- Underflow  output  1  sticky: pop rejected while empty.

## Operation
- Reset (RstN low, any time, including mid-operation): Count=0, Empty=1, Full=0, Valid=0, Data_Out=0, Overflow=0, Underflow=0, mode register=LIFO, pointers=0. Memory contents are not reset.
- Mode register: loads Mode at every rising edge where Count==0 after that edge's update. While Count≠0, Mode changes are ignored. Order never changes with data resident.
- Clear=1: Count=0, pointers=0, Overflow=Underflow=0, Valid=0, Data_Out held. Push/Pop in that cycle are ignored.
- Push only, not Full: store Data_In, Count+1.
- Push only, Full: word dropped, Overflow←1, state otherwise unchanged.
- Pop only, not Empty: Data_Out←selected word, Valid=1, Count−1.
- Pop only, Empty: Underflow←1, Valid=0, Data_Out held.
- Push+Pop, Count>0, including Full:
  - Both are effective and Count is unchanged. No Overflow.
  - LIFO: Data_Out←current top, and the top slot is overwritten with Data_In.
  - FIFO: Data_Out←oldest word, and Data_In is appended at the tail. The read and write pointers both advance.
- Push+Pop, Empty: push is effective (Count→1), pop is rejected, Underflow←1, Valid=0. There is no pass-through.
- Selected word:
  - LIFO: the most recently written unpopped word. The top index is Count−1.
  - FIFO: the oldest unpopped word. The read and write pointers wrap from DEPTH−1 to 0.
- Overflow/Underflow clear only on RstN or Clear.

## Timing
- All outputs are registered. There are no combinational paths from any input to any output.
- Pop sampled at edge N: Data_Out and Valid are updated at edge N. Valid drops at edge N+1 unless another pop is effective.
- Push at edge N: Count, Full and Empty reflect the new word after edge N. The word is poppable from edge N+1.
- Full, Empty and Count are updated on the same edge as the operation that changes them.
- Throughput is one push and/or one pop per cycle indefinitely.

## Test plan
- Reset then LIFO (Mode=0), WIDTH=8, DEPTH=4:
  - Push 0x11, 0x22, 0x33, 0x44: Full=1 and Count=4 after the 4th edge.
  - Pop ×4: Data_Out 0x44, 0x33, 0x22, 0x11, each with a one-cycle Valid. Ends Empty=1.
- FIFO (Mode=1), DEPTH=4, wrap:
  - Push A0–A3, pop 2 (A0, A1), push A4, A5, pop 4: order is A2, A3, A4, A5.
  - Check pointer wrap. Count sequence is 4, 2, 4, 0.
- Boundaries:
  - Push when Full: Overflow=1, Count stays 4. A later pop still returns the correct data.
  - Pop when Empty: Underflow=1, Valid=0, Data_Out unchanged.
  - Clear: both flags → 0, Count=0.
- Simultaneous push+pop:
  - LIFO full holding 1,2,3,4 with push 9: Data_Out=4. The next pops return 9, 3, 2, 1.
  - FIFO with Count=2 holding {5,6} and push 7: Data_Out=5, Count=2.
  - On Empty: Count=1, Underflow=1.
- Mode latch: with Count=2 in LIFO, toggle Mode to 1. Pops are still LIFO. After the drain to Empty, Mode=1 is latched and the next pushes and pops are FIFO.
- Async reset mid-burst: assert RstN low between edges during pops with Count=3. All outputs take their reset values immediately. After release, the first pop sets Underflow=1.
